// File: rtl/spi_sample_avg.sv
// spi_sample_avg: consumer of the 16-bit SPI master's receive word.
// Captures each frame on the chip-select rising edge and produces block
// average, minimum and maximum over 2^LOG2_N consecutive samples.
module spi_sample_avg #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LOG2_N = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cs,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_clr,
  output logic [DATA_W-1:0] o_sample,
  output logic              o_sample_valid,
  output logic [DATA_W-1:0] o_avg,
  output logic [DATA_W-1:0] o_min,
  output logic [DATA_W-1:0] o_max,
  output logic              o_avg_valid,
  output logic [LOG2_N-1:0] o_count
);

  localparam int unsigned ACC_W = DATA_W + LOG2_N;

  logic              r_cs_d;
  logic [DATA_W-1:0] r_sample;
  logic              r_sample_valid;
  logic [ACC_W-1:0]  r_acc;
  logic [DATA_W-1:0] r_run_min;
  logic [DATA_W-1:0] r_run_max;
  logic [LOG2_N-1:0] r_count;
  logic [DATA_W-1:0] r_avg;
  logic [DATA_W-1:0] r_min;
  logic [DATA_W-1:0] r_max;
  logic              r_avg_valid;

  logic              w_frame_end;
  logic              w_last;
  logic [ACC_W-1:0]  w_acc_sum;
  logic [DATA_W-1:0] w_avg;
  logic [DATA_W-1:0] w_min_next;
  logic [DATA_W-1:0] w_max_next;

  // Frame-end detect, window-position flag and the combinational update values
  always_comb begin
    w_frame_end = i_cs & ~r_cs_d;
    w_last      = (r_count == '1);
    w_acc_sum   = r_acc + ACC_W'(i_data);
    w_avg       = w_acc_sum[ACC_W-1:LOG2_N];
    w_min_next  = r_run_min;
    w_max_next  = r_run_max;
    if (r_count == '0) begin
      w_min_next = i_data;
      w_max_next = i_data;
    end else begin
      if (i_data < r_run_min) w_min_next = i_data;
      if (i_data > r_run_max) w_max_next = i_data;
    end
  end

  // Sample capture, window accumulation and completed-window result registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cs_d         <= 1'b1;
      r_sample       <= '0;
      r_sample_valid <= 1'b0;
      r_acc          <= '0;
      r_run_min      <= '0;
      r_run_max      <= '0;
      r_count        <= '0;
      r_avg          <= '0;
      r_min          <= '0;
      r_max          <= '0;
      r_avg_valid    <= 1'b0;
    end else begin
      r_cs_d         <= i_cs;
      r_sample_valid <= w_frame_end;
      r_avg_valid    <= 1'b0;
      if (w_frame_end) r_sample <= i_data;
      // Clear outranks a coincident frame end: the sample is shown but not counted.
      if (i_clr) begin
        r_acc     <= '0;
        r_run_min <= '0;
        r_run_max <= '0;
        r_count   <= '0;
      end else if (w_frame_end) begin
        if (w_last) begin
          r_avg       <= w_avg;
          r_min       <= w_min_next;
          r_max       <= w_max_next;
          r_avg_valid <= 1'b1;
          r_acc       <= '0;
          r_run_min   <= '0;
          r_run_max   <= '0;
          r_count     <= '0;
        end else begin
          r_acc     <= w_acc_sum;
          r_run_min <= w_min_next;
          r_run_max <= w_max_next;
          r_count   <= r_count + LOG2_N'(1);
        end
      end
    end
  end

  assign o_sample       = r_sample;
  assign o_sample_valid = r_sample_valid;
  assign o_avg          = r_avg;
  assign o_min          = r_min;
  assign o_max          = r_max;
  assign o_avg_valid    = r_avg_valid;
  assign o_count        = r_count;

endmodule

// File: tb/tb_spi_sample_avg.sv
// Testbench for spi_sample_avg: directed table vectors, hand-written corner
// sequences and randomized frames checked against a queue-based window model.
module tb_spi_sample_avg;

  logic        i_clk;
  logic        i_rst;
  logic        i_cs;
  logic [15:0] i_data;
  logic        i_clr;
  logic [15:0] o_sample;
  logic        o_sample_valid;
  logic [15:0] o_avg;
  logic [15:0] o_min;
  logic [15:0] o_max;
  logic        o_avg_valid;
  logic [2:0]  o_count;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  spi_sample_avg #(.DATA_W(16), .LOG2_N(3)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_cs(i_cs), .i_data(i_data), .i_clr(i_clr),
    .o_sample(o_sample), .o_sample_valid(o_sample_valid), .o_avg(o_avg),
    .o_min(o_min), .o_max(o_max), .o_avg_valid(o_avg_valid), .o_count(o_count)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Reference model: current window contents and last completed-window results
  logic [15:0] m_q[$];
  logic [15:0] m_sample = '0;
  logic [15:0] m_avg = '0;
  logic [15:0] m_min = '0;
  logic [15:0] m_max = '0;
  logic        m_av = 1'b0;

  typedef struct {
    logic [15:0] data;
    logic        clr;
    logic [2:0]  cnt;
    logic        av;
    logic [15:0] avg;
    logic [15:0] mn;
    logic [15:0] mx;
  } vec_t;

  vec_t tbl[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_sample = '0; m_avg = '0; m_min = '0; m_max = '0; m_av = 1'b0;
  endtask

  task automatic model_frame(input logic [15:0] v, input logic clr);
    int unsigned sum;
    m_sample = v;
    m_av = 1'b0;
    if (clr) begin
      m_q.delete();
    end else begin
      m_q.push_back(v);
      if (m_q.size() == 8) begin
        sum = 0;
        m_min = m_q[0];
        m_max = m_q[0];
        foreach (m_q[j]) begin
          sum += m_q[j];
          if (m_q[j] < m_min) m_min = m_q[j];
          if (m_q[j] > m_max) m_max = m_q[j];
        end
        m_avg = 16'(sum / 8);
        m_av  = 1'b1;
        m_q.delete();
      end
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".sample"}, 32'(o_sample), 32'(m_sample));
    check({tag, ".count"}, 32'(o_count), 32'(m_q.size()));
    check({tag, ".avg_valid"}, 32'(o_avg_valid), 32'(m_av));
    check({tag, ".avg"}, 32'(o_avg), 32'(m_avg));
    check({tag, ".min"}, 32'(o_min), 32'(m_min));
    check({tag, ".max"}, 32'(o_max), 32'(m_max));
  endtask

  // One frame: i_cs low for one cycle, then rising; frame end every 2 cycles
  task automatic do_frame(input logic [15:0] v, input logic clr);
    i_cs = 1'b0;
    i_data = v;
    tick();
    check("idle.sample_valid", 32'(o_sample_valid), 32'd0);
    check("idle.avg_valid", 32'(o_avg_valid), 32'd0);
    i_cs = 1'b1;
    i_clr = clr;
    tick();
    i_clr = 1'b0;
    model_frame(v, clr);
    check("frame.sample_valid", 32'(o_sample_valid), 32'd1);
    check_model("frame");
  endtask

  task automatic do_clear();
    i_clr = 1'b1;
    tick();
    i_clr = 1'b0;
    m_q.delete();
    m_av = 1'b0;
    check("clear.sample_valid", 32'(o_sample_valid), 32'd0);
    check_model("clear");
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".sample"}, 32'(o_sample), 32'd0);
    check({tag, ".sample_valid"}, 32'(o_sample_valid), 32'd0);
    check({tag, ".avg"}, 32'(o_avg), 32'd0);
    check({tag, ".min"}, 32'(o_min), 32'd0);
    check({tag, ".max"}, 32'(o_max), 32'd0);
    check({tag, ".avg_valid"}, 32'(o_avg_valid), 32'd0);
    check({tag, ".count"}, 32'(o_count), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Window of 1..8 (sum 36, avg 4), then three 100s, 200 with clear, eight 10s
    for (int i = 0; i < 8; i++)
      tbl[i] = '{16'(i + 1), 1'b0, 3'(i + 1), (i == 7), 16'd4, 16'd1, 16'd8};
    for (int i = 8; i < 11; i++)
      tbl[i] = '{16'd100, 1'b0, 3'(i - 7), 1'b0, 16'd0, 16'd0, 16'd0};
    tbl[11] = '{16'd200, 1'b1, 3'd0, 1'b0, 16'd0, 16'd0, 16'd0};
    for (int i = 12; i < 20; i++)
      tbl[i] = '{16'd10, 1'b0, 3'(i - 11), (i == 19), 16'd10, 16'd10, 16'd10};

    i_rst = 1'b1; i_cs = 1'b1; i_data = '0; i_clr = 1'b0;
    model_reset();

    // Reset held with i_cs high; no spurious frame after release
    repeat (3) tick();
    check_all_zero("reset");
    i_rst = 1'b0;
    tick();
    check_all_zero("post_reset");
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_cs_high.sample_valid", 32'(o_sample_valid), 32'd0);
    end

    // Single frame 0x000F
    do_frame(16'h000F, 1'b0);
    tick();
    check("single.valid_one_cycle", 32'(o_sample_valid), 32'd0);
    check("single.count_hold", 32'(o_count), 32'd1);
    do_clear();

    // Table-driven windows
    for (int i = 0; i < 20; i++) begin
      do_frame(tbl[i].data, tbl[i].clr);
      check("tbl.sample", 32'(o_sample), 32'(tbl[i].data));
      check("tbl.count", 32'(o_count), 32'(tbl[i].cnt));
      check("tbl.avg_valid", 32'(o_avg_valid), 32'(tbl[i].av));
      if (tbl[i].av) begin
        check("tbl.avg", 32'(o_avg), 32'(tbl[i].avg));
        check("tbl.min", 32'(o_min), 32'(tbl[i].mn));
        check("tbl.max", 32'(o_max), 32'(tbl[i].mx));
      end
    end
    tick();
    check("tbl.avg_valid_one_cycle", 32'(o_avg_valid), 32'd0);
    check("tbl.avg_hold", 32'(o_avg), 32'd10);

    // All-ones window then all-zeros window
    for (int i = 0; i < 8; i++) do_frame(16'hFFFF, 1'b0);
    check("ones.avg", 32'(o_avg), 32'h0000_FFFF);
    check("ones.min", 32'(o_min), 32'h0000_FFFF);
    check("ones.max", 32'(o_max), 32'h0000_FFFF);
    for (int i = 0; i < 8; i++) do_frame(16'h0000, 1'b0);
    check("zeros.avg", 32'(o_avg), 32'd0);
    check("zeros.min", 32'(o_min), 32'd0);
    check("zeros.max", 32'(o_max), 32'd0);

    // Five frames, then asynchronous reset mid-cycle
    for (int i = 0; i < 5; i++) do_frame(16'(i * 7 + 3), 1'b0);
    #3;
    i_rst = 1'b1;
    i_cs = 1'b1;
    #1;
    check_all_zero("async_reset");
    model_reset();
    tick();
    tick();
    check_all_zero("async_reset_held");
    i_rst = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) do_frame(16'h1234, 1'b0);
    check("after_reset.avg", 32'(o_avg), 32'h0000_1234);
    check("after_reset.avg_valid", 32'(o_avg_valid), 32'd1);

    // Randomized frames and clears against the window model
    for (int i = 0; i < 120; i++) begin
      logic [15:0] v;
      int unsigned r;
      r = $urandom_range(0, 99);
      v = (r < 50) ? 16'($urandom) : 16'($urandom_range(0, 40));
      if (r < 5) do_clear();
      else do_frame(v, (r >= 5 && r < 12));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
